// File: rtl/pw_feed_pkg.sv
// Shared types for the pointwise-conv input stream feeder.
//   pw_state_e : feeder control states
//   ch_width() : width needed to hold a channel count 0..max_ch
//   pw_beat_t  : one output beat {data, weight, bias, first, last}
package pw_feed_pkg;

  localparam int PW_DATA_W = 8;
  localparam int PW_ACC_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } pw_state_e;

  function automatic int ch_width(input int max_ch);
    return $clog2(max_ch + 1);
  endfunction

  typedef struct packed {
    logic signed [PW_DATA_W-1:0] data;
    logic signed [PW_DATA_W-1:0] weight;
    logic signed [PW_ACC_W-1:0]  bias;
    logic                        first;
    logic                        last;
  } pw_beat_t;

endpackage

// File: rtl/pw_act_buf.sv
// Activation buffer: DEPTH x DATA_W register file holding one pixel's
// input channels.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write channel index
//   i_wdata : activation to store
//   i_raddr : read channel index (asynchronous read)
//   o_rdata : activation at i_raddr
module pw_act_buf #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 1024,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_waddr,
  input  logic signed [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]            i_raddr,
  output logic signed [DATA_W-1:0] o_rdata
);

  logic signed [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pw_stream_feeder.sv
// Pointwise-conv input stream feeder. Buffers one pixel of depthwise
// activations, then replays them once per output channel, pairing each with
// a weight and the per-output-channel bias from 1-cycle-latency memories.
//   clk, rst                : clock, synchronous active-high reset
//   start, cfg_*            : layer launch and configuration (latched in IDLE)
//   in_valid/in_ready/in_data : upstream activation stream
//   w_rd_en/w_rd_addr/w_rd_data : weight memory port ([oc][ic] layout)
//   b_rd_addr/b_rd_data     : bias memory port (addressed by oc)
//   out_*                   : beat stream to the pointwise accumulators
//   busy, done              : layer status
module pw_stream_feeder
  import pw_feed_pkg::*;
#(
  parameter  int DATA_W  = PW_DATA_W,
  parameter  int ACC_W   = PW_ACC_W,
  parameter  int MAX_CH  = 1024,
  parameter  int WADDR_W = 20,
  localparam int CH_W    = ch_width(MAX_CH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CH_W-1:0]           cfg_in_ch,
  input  logic [CH_W-1:0]           cfg_out_ch,
  input  logic [31:0]               cfg_num_pix,
  input  logic [WADDR_W-1:0]        cfg_w_base,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  output logic                      w_rd_en,
  output logic [WADDR_W-1:0]        w_rd_addr,
  input  logic signed [DATA_W-1:0]  w_rd_data,
  output logic [CH_W-1:0]           b_rd_addr,
  input  logic signed [ACC_W-1:0]   b_rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_data,
  output logic signed [DATA_W-1:0]  out_weight,
  output logic signed [ACC_W-1:0]   out_bias,
  output logic                      out_first_in_ch,
  output logic                      out_last_in_ch,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = $clog2(MAX_CH);

  pw_state_e r_state, w_state_nxt;

  logic [CH_W-1:0]    r_in_ch, r_out_ch, r_ic, r_oc;
  logic [31:0]        r_num_pix, r_pix;
  logic [WADDR_W-1:0] r_w_base, r_waddr;
  logic               r_done;

  logic                     r_vld_p1;
  logic signed [DATA_W-1:0] r_sb_data_p1;
  logic                     r_sb_first_p1, r_sb_last_p1;

  pw_beat_t r_beat_p2, r_hold_p2, w_land;
  logic     r_vld_p2, r_hold_vld_p2;

  logic signed [DATA_W-1:0] w_act;
  logic       w_cfg_zero, w_in_fire, w_ic_last, w_oc_last, w_accept;
  logic       w_issue, w_drained, w_pix_last;
  logic [1:0] w_occ;

  assign w_cfg_zero = (cfg_in_ch == '0) || (cfg_out_ch == '0) || (cfg_num_pix == '0);
  assign w_in_fire  = (r_state == LOAD) && in_valid;
  assign w_ic_last  = (r_ic == r_in_ch - 1'b1);
  assign w_oc_last  = (r_oc == r_out_ch - 1'b1);
  assign w_accept   = r_vld_p2 && out_ready;
  assign w_pix_last = (r_pix + 32'd1 == r_num_pix);

  // Slots occupied by beats not yet accepted: output register, hold register
  // and the read whose data lands this cycle. A new read is issued only when
  // a slot is guaranteed to be free when its data lands, which keeps one read
  // in flight and still sustains one beat per cycle under full ready.
  assign w_occ     = 2'(r_vld_p2) + 2'(r_hold_vld_p2) + 2'(r_vld_p1);
  assign w_issue   = (r_state == STREAM) && ((w_occ - 2'(w_accept)) < 2'd2);
  assign w_drained = !r_vld_p1 && !r_hold_vld_p2 && (!r_vld_p2 || out_ready);

  pw_act_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_CH)
  ) u_act_buf (
    .clk     (clk),
    .i_we    (w_in_fire),
    .i_waddr (r_ic[AW-1:0]),
    .i_wdata (in_data),
    .i_raddr (r_ic[AW-1:0]),
    .o_rdata (w_act)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start && !w_cfg_zero)              w_state_nxt = LOAD;
      LOAD:    if (w_in_fire && w_ic_last)            w_state_nxt = STREAM;
      STREAM:  if (w_issue && w_ic_last && w_oc_last) w_state_nxt = DRAIN;
      DRAIN:   if (w_drained) w_state_nxt = w_pix_last ? IDLE : LOAD;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_in_ch   <= cfg_in_ch;
      r_out_ch  <= cfg_out_ch;
      r_num_pix <= cfg_num_pix;
      r_w_base  <= cfg_w_base;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ic    <= '0;
      r_oc    <= '0;
      r_pix   <= '0;
      r_waddr <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_cfg_zero) r_done <= 1'b1;
            r_ic  <= '0;
            r_pix <= '0;
          end
        end
        LOAD: begin
          if (w_in_fire) begin
            if (w_ic_last) begin
              r_ic    <= '0;
              r_oc    <= '0;
              r_waddr <= r_w_base;
            end else begin
              r_ic <= r_ic + 1'b1;
            end
          end
        end
        STREAM: begin
          // Address runs linearly through the [oc][ic] weight block.
          if (w_issue) begin
            r_waddr <= r_waddr + 1'b1;
            if (w_ic_last) begin
              r_ic <= '0;
              r_oc <= r_oc + 1'b1;
            end else begin
              r_ic <= r_ic + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_drained) begin
            r_pix <= r_pix + 32'd1;
            r_ic  <= '0;
            if (w_pix_last) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- p1: read issued; sideband captured to align with read data ----
  always_ff @(posedge clk) begin
    if (rst) r_vld_p1 <= 1'b0;
    else     r_vld_p1 <= w_issue;
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_sb_data_p1  <= w_act;
      r_sb_first_p1 <= (r_ic == '0);
      r_sb_last_p1  <= w_ic_last;
    end
  end

  always_comb begin
    w_land        = '0;
    w_land.data   = r_sb_data_p1;
    w_land.weight = w_rd_data;
    w_land.bias   = b_rd_data;
    w_land.first  = r_sb_first_p1;
    w_land.last   = r_sb_last_p1;
  end

  // ---- p2: output register, with a hold slot for data landing on a stall ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2      <= 1'b0;
      r_hold_vld_p2 <= 1'b0;
      r_beat_p2     <= '0;
      r_hold_p2     <= '0;
    end else if (!r_vld_p2 || out_ready) begin
      if (r_hold_vld_p2) begin
        r_beat_p2     <= r_hold_p2;
        r_vld_p2      <= 1'b1;
        r_hold_vld_p2 <= r_vld_p1;
        if (r_vld_p1) r_hold_p2 <= w_land;
      end else if (r_vld_p1) begin
        r_beat_p2 <= w_land;
        r_vld_p2  <= 1'b1;
      end else begin
        r_vld_p2 <= 1'b0;
      end
    end else if (r_vld_p1) begin
      r_hold_p2     <= w_land;
      r_hold_vld_p2 <= 1'b1;
    end
  end

  assign in_ready        = (r_state == LOAD);
  assign busy            = (r_state != IDLE);
  assign done            = r_done;
  assign w_rd_en         = w_issue;
  assign w_rd_addr       = r_waddr;
  assign b_rd_addr       = r_oc;
  assign out_valid       = r_vld_p2;
  assign out_data        = r_beat_p2.data;
  assign out_weight      = r_beat_p2.weight;
  assign out_bias        = r_beat_p2.bias;
  assign out_first_in_ch = r_beat_p2.first;
  assign out_last_in_ch  = r_beat_p2.last;

endmodule

// File: tb/tb_pw_stream_feeder.sv
module tb_pw_stream_feeder;
  import pw_feed_pkg::*;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 32;
  localparam int MAX_CH  = 1024;
  localparam int WADDR_W = 20;
  localparam int CH_W    = ch_width(MAX_CH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [CH_W-1:0] cfg_in_ch = '0, cfg_out_ch = '0;
  logic [31:0] cfg_num_pix = '0;
  logic [WADDR_W-1:0] cfg_w_base = '0;
  logic in_valid = 1'b0, in_ready;
  logic signed [DATA_W-1:0] in_data = '0;
  logic w_rd_en;
  logic [WADDR_W-1:0] w_rd_addr;
  logic signed [DATA_W-1:0] w_rd_data;
  logic [CH_W-1:0] b_rd_addr;
  logic signed [ACC_W-1:0] b_rd_data;
  logic out_valid, out_ready = 1'b0;
  logic signed [DATA_W-1:0] out_data, out_weight;
  logic signed [ACC_W-1:0] out_bias;
  logic out_first_in_ch, out_last_in_ch, busy, done;

  pw_stream_feeder dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch), .cfg_num_pix(cfg_num_pix),
    .cfg_w_base(cfg_w_base),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_weight(out_weight), .out_bias(out_bias),
    .out_first_in_ch(out_first_in_ch), .out_last_in_ch(out_last_in_ch),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic signed [DATA_W-1:0] wfun(input logic [WADDR_W-1:0] a);
    logic [WADDR_W-1:0] t;
    t = a - 20'h100;
    return t[DATA_W-1:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] bfun(input logic [CH_W-1:0] oc);
    return $signed(32'(oc) * 32'd1000 - 32'd7);
  endfunction

  // Memories: 1-cycle latency; garbage on cycles without a read.
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= wfun(w_rd_addr);
    else         w_rd_data <= DATA_W'($urandom);
    if (w_rd_en) b_rd_data <= bfun(b_rd_addr);
    else         b_rd_data <= $urandom;
  end

  int n_vec = 0, n_err = 0, cyc = 0;
  logic signed [DATA_W-1:0] acts[$];
  pw_beat_t got[$];
  logic [WADDR_W-1:0] rd_addrs[$];
  int start_cyc, done_cyc, done_cnt, first_vld_cyc, last_in_cyc, last_acc_cyc;
  int stall_viol, busy_seen, timed_out;

  // Reference: beat idx of the layer is (pixel, oc, ic) in nested order.
  function automatic pw_beat_t exp_beat(input int idx, input int ich, input int och,
                                        input logic [WADDR_W-1:0] base);
    int per, p, r, oc, ic;
    pw_beat_t b;
    per = ich * och; p = idx / per; r = idx % per; oc = r / ich; ic = r % ich;
    b.data   = acts[p*ich + ic];
    b.weight = wfun(base + WADDR_W'(oc*ich + ic));
    b.bias   = bfun(CH_W'(oc));
    b.first  = (ic == 0);
    b.last   = (ic == ich - 1);
    return b;
  endfunction

  function automatic logic [WADDR_W-1:0] exp_addr(input int j, input int ich, input int och,
                                                  input logic [WADDR_W-1:0] base);
    return base + WADDR_W'(j % (ich * och));
  endfunction

  task automatic fill_acts(input int n);
    acts.delete();
    for (int i = 0; i < n; i++) acts.push_back(DATA_W'($urandom));
  endtask

  // Runs one layer; records accepted beats, read addresses and timing.
  task automatic run_layer(input int ich, input int och, input int npix,
                           input logic [WADDR_W-1:0] base, input int rmode,
                           input int vmode, input int rst_at, input int restart_in_load);
    int sent;
    logic prev_stall, did_restart;
    pw_beat_t prev_b, cur;
    got.delete(); rd_addrs.delete();
    done_cyc = -1; done_cnt = 0; first_vld_cyc = -1; last_in_cyc = -1; last_acc_cyc = -1;
    stall_viol = 0; busy_seen = 0; timed_out = 1;
    sent = 0; prev_stall = 1'b0; did_restart = 1'b0; prev_b = '0;
    @(negedge clk); cyc++;
    cfg_in_ch = CH_W'(ich); cfg_out_ch = CH_W'(och); cfg_num_pix = 32'(npix);
    cfg_w_base = base; start = 1'b1; start_cyc = cyc;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); cyc++;
      start = 1'b0;
      cur = '{data: out_data, weight: out_weight, bias: out_bias,
              first: out_first_in_ch, last: out_last_in_ch};
      if (busy) busy_seen = 1;
      if (prev_stall && (!out_valid || cur !== prev_b)) stall_viol++;
      if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; timed_out = 0; break; end
      if (rst_at >= 0 && got.size() == rst_at) begin
        rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0; timed_out = 0; break;
      end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((k & 1) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin got.push_back(cur); last_acc_cyc = cyc; end
      prev_stall = out_valid && !out_ready;
      prev_b = cur;
      in_valid = 1'b0;
      if (in_ready && sent < acts.size()) begin
        in_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        in_data = acts[sent];
        if (in_valid) begin
          sent++;
          if (sent == ich && last_in_cyc < 0) last_in_cyc = cyc;
        end
      end
      if (restart_in_load != 0 && in_ready && sent == 1 && !did_restart) begin
        start = 1'b1; cfg_in_ch = CH_W'(ich + 2); cfg_out_ch = CH_W'(och + 1);
        cfg_num_pix = 32'(npix + 1); cfg_w_base = base + 20'h40; did_restart = 1'b1;
      end
      #1;
      if (w_rd_en) rd_addrs.push_back(w_rd_addr);
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) begin @(negedge clk); cyc++; end
    n_vec++;
    if ({in_ready, out_valid, w_rd_en, busy, done} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 00000", {in_ready, out_valid, w_rd_en, busy, done});
    end
    n_vec++;
    if ({out_data, out_weight, out_bias, out_first_in_ch, out_last_in_ch} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h %h %h %b %b required all zero",
               out_data, out_weight, out_bias, out_first_in_ch, out_last_in_ch);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    pw_beat_t e;
    acts.delete(); acts.push_back(8'sd5); acts.push_back(-8'sd2); acts.push_back(8'sd7);
    run_layer(3, 2, 1, 20'h100, 0, 0, -1, 0);
    n_vec++;
    if (timed_out !== 0 || got.size() !== 6) begin
      n_err++; $display("FAIL basic_count: got %0d beats (timeout %0d) required 6", got.size(), timed_out);
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      e = exp_beat(i, 3, 2, 20'h100);
      n_vec++;
      if (got[i] !== e) begin n_err++; $display("FAIL basic_beat %0d: got %h required %h", i, got[i], e); end
    end
    n_vec++;
    if (rd_addrs.size() !== 6) begin n_err++; $display("FAIL basic_reads: got %0d required 6", rd_addrs.size()); end
    for (int j = 0; j < rd_addrs.size() && j < 6; j++) begin
      n_vec++;
      if (rd_addrs[j] !== exp_addr(j, 3, 2, 20'h100)) begin
        n_err++; $display("FAIL basic_addr %0d: got %h required %h", j, rd_addrs[j], exp_addr(j, 3, 2, 20'h100));
      end
    end
    n_vec++;
    if (first_vld_cyc !== last_in_cyc + 3) begin
      n_err++; $display("FAIL basic_latency: got %0d required %0d", first_vld_cyc - last_in_cyc, 3);
    end
    n_vec++;
    if (done_cyc !== last_acc_cyc + 1 || done_cnt !== 1) begin
      n_err++; $display("FAIL basic_done: got delay %0d count %0d required 1 1", done_cyc - last_acc_cyc, done_cnt);
    end
  endtask

  task automatic test_backpressure;
    pw_beat_t e;
    acts.delete(); acts.push_back(8'sd5); acts.push_back(-8'sd2); acts.push_back(8'sd7);
    run_layer(3, 2, 1, 20'h100, 1, 0, -1, 0);
    n_vec++;
    if (timed_out !== 0 || got.size() !== 6) begin
      n_err++; $display("FAIL bp_count: got %0d beats (timeout %0d) required 6", got.size(), timed_out);
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      e = exp_beat(i, 3, 2, 20'h100);
      n_vec++;
      if (got[i] !== e) begin n_err++; $display("FAIL bp_beat %0d: got %h required %h", i, got[i], e); end
    end
    n_vec++;
    if (stall_viol !== 0) begin n_err++; $display("FAIL bp_stable: got %0d changes while stalled required 0", stall_viol); end
    n_vec++;
    if (rd_addrs.size() !== 6) begin n_err++; $display("FAIL bp_reads: got %0d required 6", rd_addrs.size()); end
    n_vec++;
    if (done_cyc !== last_acc_cyc + 1) begin
      n_err++; $display("FAIL bp_done: got delay %0d required 1", done_cyc - last_acc_cyc);
    end
  endtask

  task automatic test_in_ch1;
    pw_beat_t e;
    fill_acts(2);
    run_layer(1, 4, 2, 20'h100, 0, 0, -1, 0);
    n_vec++;
    if (timed_out !== 0 || got.size() !== 8) begin
      n_err++; $display("FAIL ich1_count: got %0d beats (timeout %0d) required 8", got.size(), timed_out);
    end
    for (int i = 0; i < got.size() && i < 8; i++) begin
      e = exp_beat(i, 1, 4, 20'h100);
      n_vec++;
      if (got[i] !== e) begin n_err++; $display("FAIL ich1_beat %0d: got %h required %h", i, got[i], e); end
    end
    n_vec++;
    if (rd_addrs.size() !== 8) begin n_err++; $display("FAIL ich1_reads: got %0d required 8", rd_addrs.size()); end
    for (int j = 0; j < rd_addrs.size() && j < 8; j++) begin
      n_vec++;
      if (rd_addrs[j] !== exp_addr(j, 1, 4, 20'h100)) begin
        n_err++; $display("FAIL ich1_addr %0d: got %h required %h", j, rd_addrs[j], exp_addr(j, 1, 4, 20'h100));
      end
    end
  endtask

  task automatic test_zero_cfg;
    int zc [3][3] = '{'{3, 0, 1}, '{0, 2, 1}, '{3, 2, 0}};
    for (int t = 0; t < 3; t++) begin
      fill_acts(zc[t][0] * zc[t][2]);
      run_layer(zc[t][0], zc[t][1], zc[t][2], 20'h100, 0, 0, -1, 0);
      n_vec++;
      if (timed_out !== 0 || done_cyc !== start_cyc + 1) begin
        n_err++; $display("FAIL zero_done %0d: got delay %0d required 1", t, done_cyc - start_cyc);
      end
      n_vec++;
      if (got.size() !== 0 || rd_addrs.size() !== 0 || busy_seen !== 0) begin
        n_err++; $display("FAIL zero_idle %0d: got beats %0d reads %0d busy %0d required 0 0 0",
                          t, got.size(), rd_addrs.size(), busy_seen);
      end
    end
  endtask

  task automatic test_reset_mid;
    pw_beat_t e;
    acts.delete(); acts.push_back(8'sd5); acts.push_back(-8'sd2); acts.push_back(8'sd7);
    run_layer(3, 2, 1, 20'h100, 0, 0, 2, 0);
    @(negedge clk); cyc++;
    n_vec++;
    if ({out_valid, busy, in_ready, w_rd_en, done} !== 5'b0) begin
      n_err++; $display("FAIL rstmid_state: got %b required 00000", {out_valid, busy, in_ready, w_rd_en, done});
    end
    rst = 1'b0;
    run_layer(3, 2, 1, 20'h100, 0, 0, -1, 0);
    n_vec++;
    if (timed_out !== 0 || got.size() !== 6) begin
      n_err++; $display("FAIL rstmid_count: got %0d beats (timeout %0d) required 6", got.size(), timed_out);
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      e = exp_beat(i, 3, 2, 20'h100);
      n_vec++;
      if (got[i] !== e) begin n_err++; $display("FAIL rstmid_beat %0d: got %h required %h", i, got[i], e); end
    end
  endtask

  task automatic test_start_in_load;
    pw_beat_t e;
    logic [WADDR_W-1:0] base;
    base = WADDR_W'($urandom);
    fill_acts(6);
    run_layer(3, 2, 2, base, 0, 0, -1, 1);
    n_vec++;
    if (timed_out !== 0 || got.size() !== 12 || done_cnt !== 1) begin
      n_err++; $display("FAIL restart_count: got %0d beats done %0d required 12 1", got.size(), done_cnt);
    end
    for (int i = 0; i < got.size() && i < 12; i++) begin
      e = exp_beat(i, 3, 2, base);
      n_vec++;
      if (got[i] !== e) begin n_err++; $display("FAIL restart_beat %0d: got %h required %h", i, got[i], e); end
    end
  endtask

  task automatic test_random;
    int ich, och, npix, nb;
    logic [WADDR_W-1:0] base;
    pw_beat_t e;
    for (int t = 0; t < 5; t++) begin
      ich = $urandom_range(1, 5); och = $urandom_range(1, 4); npix = $urandom_range(1, 3);
      base = (t % 2 == 0) ? (20'hFFFFF - WADDR_W'($urandom_range(0, 6))) : WADDR_W'($urandom);
      nb = ich * och * npix;
      fill_acts(ich * npix);
      run_layer(ich, och, npix, base, 2, 1, -1, 0);
      n_vec++;
      if (timed_out !== 0 || got.size() !== nb || rd_addrs.size() !== nb) begin
        n_err++; $display("FAIL rand%0d_count: got beats %0d reads %0d required %0d", t, got.size(), rd_addrs.size(), nb);
      end
      for (int i = 0; i < got.size() && i < nb; i++) begin
        e = exp_beat(i, ich, och, base);
        n_vec++;
        if (got[i] !== e) begin n_err++; $display("FAIL rand%0d_beat %0d: got %h required %h", t, i, got[i], e); end
      end
      for (int j = 0; j < rd_addrs.size() && j < nb; j++) begin
        n_vec++;
        if (rd_addrs[j] !== exp_addr(j, ich, och, base)) begin
          n_err++; $display("FAIL rand%0d_addr %0d: got %h required %h", t, j, rd_addrs[j], exp_addr(j, ich, och, base));
        end
      end
      n_vec++;
      if (stall_viol !== 0 || done_cyc !== last_acc_cyc + 1) begin
        n_err++; $display("FAIL rand%0d_hs: got stall changes %0d done delay %0d required 0 1",
                          t, stall_viol, done_cyc - last_acc_cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_in_ch1();
    test_zero_cfg();
    test_reset_mid();
    test_start_in_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pw_stream_feeder.md
Name: pw_stream_feeder

Overview:
- Transmit side of the pointwise-conv input stream: produces the {in_data, weight, bias, first_in_ch, last_in_ch} beat stream that pointwise 1x1 accumulators consume.
- Per pixel, buffers cfg_in_ch depthwise-output activations from an upstream valid/ready stream.
- Replays those activations once per output channel, pairing each with a weight fetched from a 1-cycle-latency weight memory and a per-output-channel bias.
- Sits between the depthwise stage output and the pointwise conv input.

Parameters:
DATA_W, 8, activation/weight width
ACC_W, 32, bias width
MAX_CH, 1024, max input/output channels; CH_W = $clog2(MAX_CH+1)
WADDR_W, 20, weight memory address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latches cfg_*; honoured only in IDLE
cfg_in_ch  in  CH_W  input channels per pixel
cfg_out_ch  in  CH_W  output channels per pixel
cfg_num_pix  in  32  pixels in the layer
cfg_w_base  in  WADDR_W  weight base address; layout [oc][ic]
in_valid  in  1  upstream activation valid
in_ready  out  1  high only in LOAD
in_data  in  DATA_W signed  activation, channel order 0..in_ch-1
w_rd_en  out  1  weight read strobe
w_rd_addr  out  WADDR_W  weight address
w_rd_data  in  DATA_W signed  weight; valid the cycle after w_rd_en
b_rd_addr  out  CH_W  bias address (= oc); issued with w_rd_en
b_rd_data  in  ACC_W signed  bias; same 1-cycle latency
out_valid  out  1  beat valid
out_ready  in  1  downstream ready
out_data  out  DATA_W signed  activation
out_weight  out  DATA_W signed  weight
out_bias  out  ACC_W signed  bias of current oc
out_first_in_ch  out  1  ic == 0
out_last_in_ch  out  1  ic == in_ch-1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when the layer completes

Behaviour:
- Reset: state IDLE; counters cleared; all outputs 0, including in_ready, out_valid, w_rd_en, busy and done. Reset mid-operation discards the buffered pixel and any in-flight read. The read data arriving the following cycle is ignored.
- FSM: IDLE -> LOAD on start.
  - If any of cfg_in_ch, cfg_out_ch, cfg_num_pix is 0, stay IDLE and pulse done the next cycle instead.
  - LOAD: in_ready=1. Each in_valid&&in_ready writes act_buf[ic], ic++. The beat with ic==in_ch-1 moves to STREAM next cycle with ic=oc=0 and waddr=cfg_w_base.
  - STREAM: issue reads (ic,oc). Advance ic and wrap to 0 with oc++. After issuing (in_ch-1, out_ch-1), go to DRAIN.
  - DRAIN: wait until the output register is empty or the final beat is accepted. Then pix++; if pix==num_pix go to IDLE and pulse done, else go to LOAD.
  - start outside IDLE is ignored.
- Output pipeline: a single output register, loaded with captured read data one cycle after w_rd_en.
  - Sideband (act_buf[ic], first, last) is registered alongside the read so it aligns with w_rd_data/b_rd_data.
  - A read is issued only if the output slot is free when the data lands: issue if (!out_valid || out_ready) && !pending_unaccepted_slot. This gives at most one read in flight.
  - Throughput: 1 beat/cycle with out_ready held high. Latency: first beat out_valid 2 cycles after entering STREAM.
- Handshake: out_* hold stable while out_valid && !out_ready. out_valid drops only after acceptance with no new data.
- Address: a running offset from cfg_w_base, incremented per read and never reset within a pixel; it returns to cfg_w_base at each new pixel. No multiplier. Wraps modulo 2^WADDR_W.
- Beats per pixel = in_ch*out_ch.
  - out_first_in_ch is set on ic==0; out_last_in_ch on ic==in_ch-1.
  - With in_ch==1 both flags are set on every beat.
  - out_bias is constant across the ic sweep for a given oc.
- LOAD does not overlap STREAM; in_ready is 0 in STREAM/DRAIN (single activation buffer).

Decomposition:
- Package pw_feed_pkg holds:
  - the state enum (IDLE, LOAD, STREAM, DRAIN)
  - a CH_W helper function
  - a beat struct {data, weight, bias, first, last}
- One sub-module, pw_act_buf: MAX_CH x DATA_W register file with one write port and one asynchronous read port.

Test Plan:
- in_ch=3, out_ch=2, num_pix=1, acts {5,-2,7}, base=0x100, weights mem[a]=a-0x100, out_ready=1 -> 6 beats data 5,-2,7,5,-2,7; weights 0..5; first on beats 0,3; last on beats 2,5; done one cycle after DRAIN completes.
- Same configuration, out_ready toggling 1010... -> identical beat sequence; outputs stable while stalled; never more than one read in flight.
- in_ch=1, out_ch=4, num_pix=2 -> 8 beats, each with first=last=1; in_ready reasserts after pixel 0; waddr restarts at base for pixel 1.
- cfg_out_ch=0 with start -> no beats, no w_rd_en, done pulse the cycle after start, busy stays 0.
- rst asserted mid-STREAM (after 2 of 6 beats) -> next cycle IDLE, out_valid=0, busy=0; a fresh start then replays the full 6-beat sequence.
- start pulsed during LOAD -> ignored; configuration unchanged; beat count matches the original configuration.
